// File: rtl/irq_round_robin_scheduler.sv
// Round-robin sequencer for 15 edge-latched interrupt requests, served one at a
// time over a valid/ack handshake, with a registered any-pending flag.
//
// state | meaning
// IDLE  | no grant presented; looks for an eligible pending source each edge
// GRANT | valid high, id held until the CPU acknowledges
module irq_round_robin_scheduler #(
  parameter logic [14:0] POLARITY_MASK = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] req,
  input  logic [14:0] enable,
  input  logic        ack,
  output logic        valid,
  output logic [3:0]  id,
  output logic        any
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t      state, state_next;
  logic [14:0] q, pending, pending_next, eff, rise, clr, eligible;
  logic [3:0]  ptr, ptr_next, winner;
  logic [4:0]  scan_idx;
  logic        found;

  assign eff      = req ^ POLARITY_MASK;
  assign rise     = eff & ~q;
  assign eligible = pending & enable;

  // Scan ptr, ptr+1, ... with wrap at 15; first eligible source wins.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < 15; k++) begin
      scan_idx = {1'b0, ptr} + 5'(k);
      if (scan_idx >= 5'd15) scan_idx = scan_idx - 5'd15;
      if (!found && eligible[scan_idx[3:0]]) begin
        found  = 1'b1;
        winner = scan_idx[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      q       <= '0;
      pending <= '0;
      ptr     <= '0;
      id      <= '0;
      any     <= 1'b0;
    end else begin
      state   <= state_next;
      q       <= eff;
      pending <= pending_next;
      ptr     <= ptr_next;
      any     <= |(pending_next & enable);
      if (state == IDLE && found) id <= winner;
    end
  end

  // A new edge on the acknowledged source survives its own clear.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clr        = '0;
    case (state)
      IDLE: if (found) state_next = GRANT;
      GRANT: begin
        if (ack) begin
          state_next = IDLE;
          clr        = 15'(1) << id;
          ptr_next   = (id == 4'd14) ? 4'd0 : id + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    pending_next = (pending & ~clr) | rise;
  end

  always_comb begin
    valid = (state == GRANT);
  end

endmodule

// File: doc/irq_round_robin_scheduler.md
# irq_round_robin_scheduler

Sequencer for the 15 request lines that feed the CPU's wide request-OR path. It samples each line through a per-input polarity mask, latches a rising edge as a pending request, and serves the pending requests one at a time to the CPU with a valid/ack handshake. Sources are served in rotating (round-robin) priority order. It also provides a registered any-pending flag, which replaces the bare 15-input OR as the CPU interrupt line.

## Interface
- PolarityMask, default 15'h0000: bit i = 1 inverts Req[i] before sampling; same role as the gate bubble mask.
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  15  raw request lines; bit i = source i.
- Enable  input  15  per-source enable; disabled sources still latch pending but are never selected.
- Ack  input  1  CPU acknowledge of the currently granted source.
- Valid  output  1  a grant is being presented.
- Id  output  4  index 0..14 of the granted source; value 15 is never driven.
- Any  output  1  registered OR of (pending & Enable).

## Operation
- Effective request: eff[i] = Req[i] ^ PolarityMask[i].
- Each cycle, eff is registered into q[14:0]. edge[i] = eff[i] & ~q[i].
- At each clock edge, pending[i] is set when edge[i]=1. It is cleared only when source i is acknowledged.
  - If set and clear hit the same bit in the same cycle, set wins, so the new edge is not lost.
- Rotating pointer ptr[3:0], range 0..14. Selection order is ptr, ptr+1, …, 14, 0, …, ptr-1. The first i with pending[i] & Enable[i] wins.
- State machine with two states:
  - IDLE: Valid=0. If any eligible pending bit exists at the edge, register winner into Id, assert Valid, go to GRANT. Otherwise stay in IDLE.
  - GRANT: Valid=1, Id held stable.
    - Ack=1 at the edge: clear pending[Id], set ptr = (Id==14) ? 0 : Id+1, drop Valid, go to IDLE.
    - Ack=0: stay in GRANT.
- A grant is never withdrawn. Enable[Id] dropping during GRANT does not alter Valid or Id.
- Ack in IDLE is ignored: no pending change, no ptr change.
- Any is recomputed every cycle from the next-state pending and Enable values. It stays high while a granted source's pending bit is still set.

## Timing
- Reset values: Valid=0, Id=0, Any=0, state=IDLE, ptr=0, pending=0, q=0.
  - Because q resets to 0, an eff level that is high at reset release counts as an edge on the first cycle after reset.
  - With PolarityMask bits set and Req low, those sources become pending immediately.
- Reset asserted mid-grant: all of the above take effect at that edge, regardless of Ack.
- Latency from eff rising (first edge where it is sampled high, edge k):
  - pending and Any become 1 after edge k.
  - Valid=1 with the correct Id after edge k+1, provided the scheduler was in IDLE.
- Ack to next grant:
  - Valid=0 for exactly one cycle after the ack edge.
  - The next grant appears after the following edge, so the minimum grant spacing is 2 cycles.
- Any drops the cycle after the ack edge if no other eligible pending bits remain.
- Held-high Req produces only one pending event. Another pending event requires eff to fall and rise again, at least one cycle low as sampled.

## Test plan
- **Reset/polarity:** PolarityMask=15'h0001, Req=0, Enable=all ones, Reset released at cycle 0.
  - Required: pending[0] after cycle 1, Valid=1 Id=0 after cycle 2; no other Id ever issued.
- **Single request latency:** Req[5] rises, sampled at edge k.
  - Required: Any=1 after k, Valid=1 Id=5 after k+1.
  - Ack at k+3: Valid=0 and Any=0 after k+3; ptr=6.
- **Round-robin fairness:** Req[3], Req[7] and Req[14] pulse together with ptr=8, Ack each grant immediately.
  - Required order: 14, 3, 7, each grant separated by one idle cycle.
- **Simultaneous set/clear:** Req[2] re-pulses so its edge lands on the same cycle Ack clears source 2.
  - Required: pending[2] remains 1 and source 2 is granted again after IDLE.
- **Enable gating and grant stability:**
  - Enable[9]=0 with pending[9] set: no grant for 9 and Any=0.
  - Raise Enable[9]: grant Id=9 after 1 cycle.
  - Drop Enable[9] during GRANT: Valid and Id unchanged until Ack.
- **Reset mid-operation:** Reset=1 during GRANT with Ack=1 and three sources pending.
  - Required: Valid=0, Any=0, ptr=0 and pending cleared after that edge.
